// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the two-digit seven-segment display driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}; digit enables
// are active-low with an[0] = units and an[1] = tens.
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    localparam digit_t     DIGIT_TEN = 4'd10;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational decode of one decimal digit into an active-low segment
// pattern. Values above 9 never occur in normal use and decode to blank.
//   i_digit : digit value 0..9
//   o_seg   : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  digit_t     i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_display_driver.sv
// -----------------------------------------------------------------------------
// seg7_display_driver
// Latches a 4-bit binary value plus a "greater than 9" flag, splits it into
// tens/units decimal digits and time-multiplexes them onto a two-digit
// common-anode seven-segment display.
//
// Ports:
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   binary_code  : 4-bit value to display
//   comparation  : 1 when binary_code > 9
//   load         : one-cycle strobe latching binary_code / comparation
//   an[1:0]      : active-low digit enables (an[0] units, an[1] tens)
//   seg[6:0]     : active-low segments {g,f,e,d,c,b,a}
//
// Parameter:
//   REFRESH_DIV  : clock cycles each digit stays active (>= 2)
//
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, a zero tens digit is blanked
//                           (an=11, seg=blank) instead of showing "0".
// -----------------------------------------------------------------------------
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] binary_code,
    input  logic       comparation,
    input  logic       load,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    digit_t           r_code;
    logic             r_comp;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [1:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_tens_one;
    digit_t           w_units;
    digit_t           w_tens;
    digit_t           w_digit;
    logic [6:0]       w_seg_dec;
    logic [1:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;

    // Input latch: a flagged value below ten is inconsistent and raises the
    // error flag until the next consistent load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= '0;
            r_comp <= 1'b0;
            r_err  <= 1'b0;
        end else if (load) begin
            r_code <= binary_code;
            r_comp <= comparation;
            r_err  <= comparation && (binary_code < DIGIT_TEN);
        end
    end

    // Refresh timer: digit select flips on the same cycle the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_sel <= ~r_sel;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Digit split. In the error case the digit values are irrelevant because
    // the output stage substitutes a dash.
    assign w_tens_one = r_comp & ~r_err;
    assign w_units    = w_tens_one ? (r_code - DIGIT_TEN) : r_code;
    assign w_tens     = {3'b000, w_tens_one};
    assign w_digit    = r_sel ? w_tens : w_units;

    bcd_to_seg7 u_dec (
        .i_digit (w_digit),
        .o_seg   (w_seg_dec)
    );

    always_comb begin
        w_an_nxt  = r_sel ? AN_TENS : AN_UNITS;
        w_seg_nxt = r_err ? SEG_DASH : w_seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
        if (r_sel && !w_tens_one && !r_err) begin
            w_an_nxt  = AN_OFF;
            w_seg_nxt = SEG_BLANK;
        end
`endif
    end

    // Output register: reflects select and latched value one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg7_display_driver.sv
module tb_seg7_display_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] binary_code = 4'd0;
    logic       comparation = 1'b0;
    logic       load = 1'b0;
    logic [1:0] an;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;
    int k = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [1:0] TENS0_AN  = 2'b11;
    localparam logic [6:0] TENS0_SEG = 7'b1111111;
`else
    localparam logic [1:0] TENS0_AN  = 2'b01;
    localparam logic [6:0] TENS0_SEG = 7'b1000000;
`endif

    seg7_display_driver #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .binary_code (binary_code),
        .comparation (comparation),
        .load        (load),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One active edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    // Edge k (1-based after reset release) shows units for edges 1..4, tens 5..8, ...
    function automatic bit units_slot(input int kk);
        return (((kk - 1) / 4) % 2) == 0;
    endfunction

    // Advance until the next four edges fall in the units slot.
    task automatic align();
        while ((k % 8) != 0) step();
    endtask

    task automatic test_reset();
        logic [1:0] ea;
        logic [6:0] es;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 2'b11 || seg !== 7'b1111111) begin
                errors++;
                $display("FAIL reset_hold: an=%b seg=%b, expected an=11 seg=1111111", an, seg);
            end
        end
        rst = 1'b0;
        k = 0;
        step();
        checks++;
        if (an !== 2'b10 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_first_edge: an=%b seg=%b, expected an=10 seg=1000000", an, seg);
        end
        for (int i = 0; i < 11; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : TENS0_AN;
            es = units_slot(k) ? 7'b1000000 : TENS0_SEG;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL refresh_after_reset k=%0d: an=%b seg=%b, expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_load_units();
        logic [1:0] ea;
        logic [6:0] es;
        align();
        binary_code = 4'b0110; comparation = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (an !== 2'b10 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL load6_latency: an=%b seg=%b, expected an=10 seg=1000000", an, seg);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : TENS0_AN;
            es = units_slot(k) ? 7'b0000010 : TENS0_SEG;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL load6 k=%0d: an=%b seg=%b, expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_load_tens();
        logic [1:0] ea;
        logic [6:0] es;
        align();
        binary_code = 4'b1100; comparation = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (an !== 2'b10 || seg !== 7'b0000010) begin
            errors++;
            $display("FAIL load12_latency: an=%b seg=%b, expected an=10 seg=0000010", an, seg);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : 2'b01;
            es = units_slot(k) ? 7'b0100100 : 7'b1111001;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL load12 k=%0d: an=%b seg=%b, expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_load_max();
        logic [1:0] ea;
        logic [6:0] es;
        align();
        binary_code = 4'b1111; comparation = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (an !== 2'b10 || seg !== 7'b0100100) begin
            errors++;
            $display("FAIL load15_latency: an=%b seg=%b, expected an=10 seg=0100100", an, seg);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : 2'b01;
            es = units_slot(k) ? 7'b0010010 : 7'b1111001;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL load15 k=%0d: an=%b seg=%b, expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_error();
        logic [1:0] ea;
        logic [6:0] es;
        align();
        binary_code = 4'b0101; comparation = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : 2'b01;
            checks++;
            if (an !== ea || seg !== 7'b0111111) begin
                errors++;
                $display("FAIL error_dash k=%0d: an=%b seg=%b, expected an=%b seg=0111111", k, an, seg, ea);
            end
        end
        align();
        binary_code = 4'b1001; comparation = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (an !== 2'b10 || seg !== 7'b0111111) begin
            errors++;
            $display("FAIL error_clear_latency: an=%b seg=%b, expected an=10 seg=0111111", an, seg);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : TENS0_AN;
            es = units_slot(k) ? 7'b0010000 : TENS0_SEG;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL error_clear k=%0d: an=%b seg=%b, expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ea;
        logic [6:0] es;
        while ((k % 8) != 5) step();
        rst = 1'b1; load = 1'b1; binary_code = 4'b1100; comparation = 1'b1;
        step();
        checks++;
        if (an !== 2'b11 || seg !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_mid_hold: an=%b seg=%b, expected an=11 seg=1111111", an, seg);
        end
        rst = 1'b0; load = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ea = units_slot(k) ? 2'b10 : TENS0_AN;
            es = units_slot(k) ? 7'b1000000 : TENS0_SEG;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL reset_mid_restart k=%0d: an=%b seg=%b, expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_units();
        test_load_tens();
        test_load_max();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
